fetch_target_queue: RTL and testbench

FETCH_TARGET_QUEUE -- requirements
Module: fetch_target_queue

---
 rtl/fetch_target_queue_pkg.sv | 12 +
 rtl/fetch_queue_ram.sv | 39 +++
 rtl/fetch_target_queue.sv | 84 ++++++++
 tb/tb_fetch_target_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_target_queue_pkg.sv
// Shared BPU/frontend definitions: global fetch width and the fetch-block entry.
package fetch_target_queue_pkg;

  localparam int CFG_FETCH_WIDTH = 4;
  localparam int PC_W            = 32;

  typedef struct packed {
    logic [PC_W-1:0]            pc;
    logic [CFG_FETCH_WIDTH-1:0] mask;
  } fetch_block_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch-block storage: DEPTH entries, one write port, one asynchronous read port.
module fetch_queue_ram
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int FETCH_WIDTH = CFG_FETCH_WIDTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [PC_W-1:0]        i_wr_pc,
  input  logic [FETCH_WIDTH-1:0] i_wr_mask,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [PC_W-1:0]        o_rd_pc,
  output logic [FETCH_WIDTH-1:0] o_rd_mask
);

  logic [PC_W-1:0]        r_pc   [DEPTH];
  logic [FETCH_WIDTH-1:0] r_mask [DEPTH];

  // Every entry clears on reset so an empty queue presents zeros at the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pc[gi]   <= '0;
        r_mask[gi] <= '0;
      end else if (i_wr_en && (i_wr_addr == AW'(gi))) begin
        r_pc[gi]   <= i_wr_pc;
        r_mask[gi] <= i_wr_mask;
      end
    end
  end

  assign o_rd_pc   = r_pc[i_rd_addr];
  assign o_rd_mask = r_mask[i_rd_addr];

endmodule

// File: rtl/fetch_target_queue.sv
// First-word-fall-through queue of predicted fetch blocks between the BPU and the I-cache.
module fetch_target_queue
  import fetch_target_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = CFG_FETCH_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         enq_valid_i,
  input  logic [31:0]                  enq_pc_i,
  input  logic [FETCH_WIDTH-1:0]       enq_mask_i,
  output logic                         enq_ready_o,
  output logic                         deq_valid_o,
  output logic [31:0]                  deq_pc_o,
  output logic [FETCH_WIDTH-1:0]       deq_mask_o,
  input  logic                         deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_enq_fire;
  logic w_store;
  logic w_deq_fire;

  // Ready/valid come only from registered count; no same-cycle bypass.
  assign enq_ready_o = (r_count != FULL_COUNT);
  assign deq_valid_o = (r_count != '0);

  assign w_enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign w_deq_fire = deq_valid_o && deq_ready_i && !flush_i;
  // Empty-mask blocks complete the handshake but carry no instructions.
  assign w_store    = w_enq_fire && (|enq_mask_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_deq_fire) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_store, w_deq_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_queue_ram #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_store),
    .i_wr_addr (r_tail),
    .i_wr_pc   (enq_pc_i),
    .i_wr_mask (enq_mask_i),
    .i_rd_addr (r_head),
    .o_rd_pc   (deq_pc_o),
    .o_rd_mask (deq_mask_o)
  );

  assign count_o = r_count;

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed and random stimulus for fetch_target_queue against a queue-based reference model.
module tb_fetch_target_queue;

  localparam int FW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          enq_valid_i = 1'b0;
  logic [31:0]   enq_pc_i = '0;
  logic [FW-1:0] enq_mask_i = '0;
  logic          enq_ready_o;
  logic          deq_valid_o;
  logic [31:0]   deq_pc_o;
  logic [FW-1:0] deq_mask_o;
  logic          deq_ready_i = 1'b0;
  logic [CW-1:0] count_o;

  fetch_target_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_pc_i    (enq_pc_i),
    .enq_mask_i  (enq_mask_i),
    .enq_ready_o (enq_ready_o),
    .deq_valid_o (deq_valid_o),
    .deq_pc_o    (deq_pc_o),
    .deq_mask_o  (deq_mask_o),
    .deq_ready_i (deq_ready_i),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   pc;
    logic [FW-1:0] mask;
  } blk_t;

  blk_t model_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, 64'(count_o), 64'(model_q.size()));
    chk({tag, ".enq_ready"}, 64'(enq_ready_o), 64'(model_q.size() != DEPTH));
    chk({tag, ".deq_valid"}, 64'(deq_valid_o), 64'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      chk({tag, ".deq_pc"}, 64'(deq_pc_o), 64'(model_q[0].pc));
      chk({tag, ".deq_mask"}, 64'(deq_mask_o), 64'(model_q[0].mask));
    end
  endtask

  // One clock of stimulus: drive, check state-derived outputs, advance model, clock.
  task automatic cycle(input logic ev, input logic [31:0] pc, input logic [FW-1:0] m,
                       input logic dr, input logic fl, input string tag);
    bit enq_ok;
    bit deq_ok;
    blk_t b;
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_mask_i  = m;
    deq_ready_i = dr;
    flush_i     = fl;
    #1;
    check_outputs(tag);
    vectors++;
    enq_ok = ev && (model_q.size() != DEPTH) && !fl;
    deq_ok = dr && (model_q.size() != 0) && !fl;
    $display("cyc %0d %s enq_v=%0b pc=%08h mask=%b deq_r=%0b flush=%0b count=%0d enq_acc=%0b deq_acc=%0b",
             cyc, tag, ev, pc, m, dr, fl, count_o, enq_ok, deq_ok);
    if (fl) begin
      model_q.delete();
    end else begin
      if (deq_ok) void'(model_q.pop_front());
      if (enq_ok && (m != '0)) begin
        b.pc   = pc;
        b.mask = m;
        model_q.push_back(b);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    bit          pending;
    logic [31:0] rpc;
    logic [FW-1:0] rmask;

    // Reset held: outputs at their cleared values.
    #3;
    check_outputs("rst");
    chk("rst.pc", 64'(deq_pc_o), 64'h0);
    chk("rst.mask", 64'(deq_mask_o), 64'h0);
    vectors++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      chk("idle.pc", 64'(deq_pc_o), 64'h0);
      chk("idle.mask", 64'(deq_mask_o), 64'h0);
      idle("idle");
    end

    // Single pass with the consumer stalled.
    cycle(1'b1, 32'h1C00_0000, 4'b1111, 1'b0, 1'b0, "single");
    idle("single.out");
    drain("single.drain");

    // Fill past capacity; the 5th block is held by the source until accepted.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h1C00_0000 + 32'(i * 16), 4'b1111, 1'b0, 1'b0, "fill");
    pending = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bit rdy;
      rdy = (model_q.size() != DEPTH);
      cycle(pending, 32'h1C00_0040, 4'b1111, 1'b1, 1'b0, "fill.drain");
      if (rdy) pending = 1'b0;
    end

    // Steady-state simultaneous enqueue and dequeue at count 2.
    cycle(1'b1, 32'h1C00_1000, 4'b0011, 1'b0, 1'b0, "sim.pre");
    cycle(1'b1, 32'h1C00_1010, 4'b0101, 1'b0, 1'b0, "sim.pre");
    for (int i = 2; i < 10; i++)
      cycle(1'b1, 32'h1C00_1000 + 32'(i * 16), 4'b1001, 1'b1, 1'b0, "sim");
    drain("sim.drain");

    // Flush at count 3 with concurrent enqueue and dequeue, then redirect target.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h1C00_2000 + 32'(i * 16), 4'b1111, 1'b0, 1'b0, "flush.pre");
    cycle(1'b1, 32'h1C00_2030, 4'b1111, 1'b1, 1'b1, "flush");
    cycle(1'b1, 32'h1C00_0104, 4'b1110, 1'b0, 1'b0, "redir");
    idle("redir.out");
    drain("redir.drain");

    // Zero-mask blocks: accepted but never stored, empty and partially full.
    cycle(1'b1, 32'h1C00_0200, 4'b0000, 1'b0, 1'b0, "zmask");
    idle("zmask.after");
    cycle(1'b1, 32'h1C00_0300, 4'b0110, 1'b0, 1'b0, "zmask.pre");
    cycle(1'b1, 32'h1C00_0310, 4'b0000, 1'b0, 1'b0, "zmask.mid");
    idle("zmask.mid.after");
    drain("zmask.drain");

    // Asynchronous reset mid-operation, asserted away from the clock edge.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h1C00_3000 + 32'(i * 16), 4'b1111, 1'b0, 1'b0, "mrst.pre");
    enq_valid_i = 1'b1;
    enq_pc_i    = 32'h1C00_3030;
    enq_mask_i  = 4'b1111;
    deq_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    check_outputs("mrst");
    chk("mrst.pc", 64'(deq_pc_o), 64'h0);
    chk("mrst.mask", 64'(deq_mask_o), 64'h0);
    vectors++;
    @(posedge clk);
    enq_valid_i = 1'b0;
    deq_ready_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("mrst.after");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rpc   = $urandom() & 32'hFFFF_FFF0;
      rmask = ($urandom_range(0, 5) == 0) ? '0 : FW'($urandom());
      cycle(1'($urandom_range(0, 3) != 0), rpc, rmask,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
